// File: rtl/rni_wdata_pack_pkg.sv
// Shared constants and FSM state encoding for the RNI write-data packing stage.
package rni_wdata_pack_pkg;

    localparam int unsigned RNI_SLOT_NUM   = 4;
    localparam int unsigned RNI_SLOT_BYTES = 16;

    localparam logic [1:0] RNI_DATAID_LO = 2'b00;
    localparam logic [1:0] RNI_DATAID_HI = 2'b10;

    typedef enum logic [1:0] {
        RNI_WPACK_IDLE  = 2'd0,
        RNI_WPACK_FILL  = 2'd1,
        RNI_WPACK_SEND0 = 2'd2,
        RNI_WPACK_SEND1 = 2'd3
    } wpack_state_e;

endpackage

// File: rtl/rni_wpack_slot.sv
// One 16B line-buffer slot: strobe-merged byte writes plus byte-enable accumulation.
module rni_wpack_slot
    import rni_wdata_pack_pkg::*;
#(
    parameter int unsigned DATA_W = RNI_SLOT_BYTES * 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                clr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W/8-1:0] be
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] data_d, data_q;
    logic [NB-1:0]     be_d, be_q;

    always_comb begin
        data_d = data_q;
        be_d   = be_q;
        if (clr) begin
            be_d = '0;
        end
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    data_d[8*b +: 8] = wdata[8*b +: 8];
                    be_d[b]          = 1'b1;
                end
            end
        end
    end

    // Data storage is deliberately not reset; only the byte enables qualify it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            be_q <= '0;
        end else begin
            be_q <= be_d;
        end
    end

    assign data = data_q;
    assign be   = be_q;

endmodule

// File: rtl/rni_wdata_pack.sv
// Packs AXI W beats into a 64B line and drains it as up to two CHI DAT flits.
// Optional RNI_WPACK_DATACHECK_EN adds per-byte odd parity on dat_datacheck.
module rni_wdata_pack
    import rni_wdata_pack_pkg::*;
#(
    parameter int unsigned AXI_DATA_W = 128,
    parameter int unsigned CHI_DATA_W = 256,
    parameter int unsigned SLOT_NUM   = RNI_SLOT_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [AXI_DATA_W-1:0]   wd_data,
    input  logic [AXI_DATA_W/8-1:0] wd_strb,
    input  logic [SLOT_NUM-1:0]     fdmask,
    input  logic                    bk_done,
    input  logic                    rq_done,
    output logic                    dat_valid,
    input  logic                    dat_ready,
    output logic [CHI_DATA_W-1:0]   dat_data,
    output logic [CHI_DATA_W/8-1:0] dat_be,
    output logic [1:0]              dat_dataid,
    output logic                    dat_last,
`ifdef RNI_WPACK_DATACHECK_EN
    output logic [CHI_DATA_W/8-1:0] dat_datacheck,
`endif
    output logic                    busy
);

    localparam int unsigned SB = AXI_DATA_W / 8;

    wpack_state_e          state_d, state_q;
    logic [SLOT_NUM-1:0]   touched_d, touched_q;
    logic                  dat_valid_d, dat_valid_q;
    logic                  dat_last_d, dat_last_q;
    logic                  wd_ready_d, wd_ready_q;
    logic                  busy_d, busy_q;

    logic wd_fire, line_clr;
    logic [AXI_DATA_W-1:0] slot_data [SLOT_NUM];
    logic [SB-1:0]         slot_be   [SLOT_NUM];

    assign wd_fire  = wd_valid & wd_ready_q;
    assign line_clr = dat_valid_q & dat_ready & dat_last_q;

    for (genvar i = 0; i < SLOT_NUM; i++) begin : g_slot
        rni_wpack_slot #(
            .DATA_W (AXI_DATA_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .we    (wd_fire & fdmask[i]),
            .clr   (line_clr),
            .wdata (wd_data),
            .wstrb (wd_strb),
            .data  (slot_data[i]),
            .be    (slot_be[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        touched_d = touched_q;
        unique case (state_q)
            RNI_WPACK_IDLE, RNI_WPACK_FILL: begin
                if (wd_fire) begin
                    touched_d = touched_q | fdmask;
                    if (rq_done) begin
                        state_d = (|touched_d[1:0]) ? RNI_WPACK_SEND0 : RNI_WPACK_SEND1;
                    end else begin
                        state_d = RNI_WPACK_FILL;
                    end
                end
            end
            RNI_WPACK_SEND0: begin
                if (dat_ready) begin
                    if (|touched_q[3:2]) begin
                        state_d = RNI_WPACK_SEND1;
                    end else begin
                        state_d   = RNI_WPACK_IDLE;
                        touched_d = '0;
                    end
                end
            end
            RNI_WPACK_SEND1: begin
                if (dat_ready) begin
                    state_d   = RNI_WPACK_IDLE;
                    touched_d = '0;
                end
            end
            default: state_d = RNI_WPACK_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        dat_valid_d = (state_d == RNI_WPACK_SEND0) || (state_d == RNI_WPACK_SEND1);
        dat_last_d  = (state_d == RNI_WPACK_SEND1) ||
                      ((state_d == RNI_WPACK_SEND0) && !(|touched_d[3:2]));
        wd_ready_d  = (state_d == RNI_WPACK_IDLE) || (state_d == RNI_WPACK_FILL);
        busy_d      = (state_d != RNI_WPACK_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RNI_WPACK_IDLE;
            touched_q   <= '0;
            dat_valid_q <= 1'b0;
            dat_last_q  <= 1'b0;
            wd_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            touched_q   <= touched_d;
            dat_valid_q <= dat_valid_d;
            dat_last_q  <= dat_last_d;
            wd_ready_q  <= wd_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        if (state_q == RNI_WPACK_SEND1) begin
            dat_data   = {slot_data[3], slot_data[2]};
            dat_be     = {slot_be[3], slot_be[2]};
            dat_dataid = RNI_DATAID_HI;
        end else begin
            dat_data   = {slot_data[1], slot_data[0]};
            dat_be     = {slot_be[1], slot_be[0]};
            dat_dataid = RNI_DATAID_LO;
        end
    end

    assign wd_ready  = wd_ready_q;
    assign dat_valid = dat_valid_q;
    assign dat_last  = dat_last_q;
    assign busy      = busy_q;

`ifdef RNI_WPACK_DATACHECK_EN
    always_comb begin
        dat_datacheck = '0;
        for (int b = 0; b < CHI_DATA_W / 8; b++) begin
            dat_datacheck[b] = ~(^dat_data[8*b +: 8]);
        end
    end
`endif

`ifndef SYNTHESIS
    // Slot select may only move on after a beat that completed its slot.
    logic                hold_q;
    logic [SLOT_NUM-1:0] hold_mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else if (wd_fire) begin
            hold_q      <= ~(bk_done | rq_done);
            hold_mask_q <= fdmask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wd_fire) begin
            assert ($onehot(fdmask))
            else $error("rni_wdata_pack: fdmask %b not one-hot on beat", fdmask);
            assert (!hold_q || (fdmask == hold_mask_q))
            else $error("rni_wdata_pack: slot select changed without bk_done");
        end
    end
`endif

endmodule

// File: tb/tb_rni_wdata_pack.sv
// Directed bench for rni_wdata_pack: full line, narrow merge, upper-half, backpressure, reset.
module tb_rni_wdata_pack;

    logic         clk = 1'b0;
    logic         rst;
    logic         wd_valid;
    logic         wd_ready;
    logic [127:0] wd_data;
    logic [15:0]  wd_strb;
    logic [3:0]   fdmask;
    logic         bk_done;
    logic         rq_done;
    logic         dat_valid;
    logic         dat_ready;
    logic [255:0] dat_data;
    logic [31:0]  dat_be;
    logic [1:0]   dat_dataid;
    logic         dat_last;
    logic         busy;
`ifdef RNI_WPACK_DATACHECK_EN
    logic [31:0]  dat_datacheck;
`endif

    int errors = 0;
    int checks = 0;

    rni_wdata_pack u_dut (
        .clk        (clk),
        .rst        (rst),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .wd_strb    (wd_strb),
        .fdmask     (fdmask),
        .bk_done    (bk_done),
        .rq_done    (rq_done),
        .dat_valid  (dat_valid),
        .dat_ready  (dat_ready),
        .dat_data   (dat_data),
        .dat_be     (dat_be),
        .dat_dataid (dat_dataid),
        .dat_last   (dat_last),
`ifdef RNI_WPACK_DATACHECK_EN
        .dat_datacheck (dat_datacheck),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns #1 after the accepting edge.
    task automatic beat(input logic [3:0] m, input logic [15:0] s, input logic [127:0] d,
                        input logic bk, input logic rq);
        int n;
        n        = 0;
        wd_valid = 1'b1;
        fdmask   = m;
        wd_strb  = s;
        wd_data  = d;
        bk_done  = bk;
        rq_done  = rq;
        while (!wd_ready && n < 20) begin
            step();
            n++;
        end
        if (!wd_ready) check("wd_ready_timeout", {255'd0, wd_ready}, 256'd1);
        step();
        wd_valid = 1'b0;
        bk_done  = 1'b0;
        rq_done  = 1'b0;
    endtask

    logic [127:0] d0, d1, d2, d3, na, nb, up;

    initial begin
        rst       = 1'b1;
        wd_valid  = 1'b0;
        wd_data   = '0;
        wd_strb   = '0;
        fdmask    = 4'b0001;
        bk_done   = 1'b0;
        rq_done   = 1'b0;
        dat_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("reset_dat_valid", {255'd0, dat_valid}, 256'd0);
        check("reset_busy",      {255'd0, busy},      256'd0);
        check("reset_wd_ready",  {255'd0, wd_ready},  256'd1);

        // Full line, four slots, two flits.
        d0 = {16{8'h10}};
        d1 = {16{8'h21}};
        d2 = {16{8'h32}};
        d3 = {16{8'h43}};
        beat(4'b0001, 16'hFFFF, d0, 1'b1, 1'b0);
        check("full_busy_fill", {255'd0, busy}, 256'd1);
        beat(4'b0010, 16'hFFFF, d1, 1'b1, 1'b0);
        beat(4'b0100, 16'hFFFF, d2, 1'b1, 1'b0);
        beat(4'b1000, 16'hFFFF, d3, 1'b1, 1'b1);
        check("full_f0_valid",  {255'd0, dat_valid},  256'd1);
        check("full_f0_dataid", {254'd0, dat_dataid}, 256'd0);
        check("full_f0_be",     {224'd0, dat_be},     {224'd0, 32'hFFFF_FFFF});
        check("full_f0_last",   {255'd0, dat_last},   256'd0);
        check("full_f0_data",   dat_data,             {d1, d0});
        check("full_f0_wdrdy",  {255'd0, wd_ready},   256'd0);
        step();
        check("full_f1_valid",  {255'd0, dat_valid},  256'd1);
        check("full_f1_dataid", {254'd0, dat_dataid}, 256'd2);
        check("full_f1_be",     {224'd0, dat_be},     {224'd0, 32'hFFFF_FFFF});
        check("full_f1_last",   {255'd0, dat_last},   256'd1);
        check("full_f1_data",   dat_data,             {d3, d2});
        check("full_f1_wdrdy",  {255'd0, wd_ready},   256'd0);
        step();
        check("full_end_valid", {255'd0, dat_valid},  256'd0);
        check("full_end_busy",  {255'd0, busy},       256'd0);
        check("full_end_wdrdy", {255'd0, wd_ready},   256'd1);

        // Narrow merge into slot 0.
        na = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        nb = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        beat(4'b0001, 16'h00FF, na, 1'b0, 1'b0);
        beat(4'b0001, 16'hFF00, nb, 1'b1, 1'b1);
        check("narrow_valid",  {255'd0, dat_valid},  256'd1);
        check("narrow_dataid", {254'd0, dat_dataid}, 256'd0);
        check("narrow_be",     {224'd0, dat_be},     {224'd0, 32'h0000_FFFF});
        check("narrow_last",   {255'd0, dat_last},   256'd1);
        check("narrow_data",   {128'd0, dat_data[127:0]},
              {128'd0, 128'hFFEEDDCC_BBAA9988_07060504_03020100});
        step();
        check("narrow_end_valid", {255'd0, dat_valid}, 256'd0);

        // Upper half only: SEND0 skipped.
        up = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;
        beat(4'b0100, 16'hFFFF, up, 1'b1, 1'b1);
        check("upper_valid",  {255'd0, dat_valid},  256'd1);
        check("upper_dataid", {254'd0, dat_dataid}, 256'd2);
        check("upper_be",     {224'd0, dat_be},     {224'd0, 32'h0000_FFFF});
        check("upper_last",   {255'd0, dat_last},   256'd1);
        check("upper_data",   {128'd0, dat_data[127:0]}, {128'd0, up});
        step();
        check("upper_end_valid", {255'd0, dat_valid}, 256'd0);

        // Backpressure on the first flit; a pending beat must not be merged.
        d0 = {16{8'h5A}};
        d1 = {16{8'h6B}};
        d2 = {16{8'h7C}};
        d3 = {16{8'h8D}};
        dat_ready = 1'b0;
        beat(4'b0001, 16'hFFFF, d0, 1'b1, 1'b0);
        beat(4'b0010, 16'hFFFF, d1, 1'b1, 1'b0);
        beat(4'b0100, 16'hFFFF, d2, 1'b1, 1'b0);
        beat(4'b1000, 16'hFFFF, d3, 1'b1, 1'b1);
        wd_valid = 1'b1;
        fdmask   = 4'b0001;
        wd_strb  = 16'hFFFF;
        wd_data  = {16{8'hEE}};
        bk_done  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  {255'd0, dat_valid},  256'd1);
            check("bp_data",   dat_data,             {d1, d0});
            check("bp_dataid", {254'd0, dat_dataid}, 256'd0);
            check("bp_wdrdy",  {255'd0, wd_ready},   256'd0);
            step();
        end
        wd_valid  = 1'b0;
        bk_done   = 1'b0;
        check("bp_hold_data", dat_data, {d1, d0});
        dat_ready = 1'b1;
        step();
        check("bp_f1_dataid", {254'd0, dat_dataid}, 256'd2);
        check("bp_f1_data",   dat_data,             {d3, d2});
        check("bp_f1_last",   {255'd0, dat_last},   256'd1);
        step();
        check("bp_end_valid", {255'd0, dat_valid},  256'd0);

        // Reset while the first flit is stalled.
        dat_ready = 1'b0;
        beat(4'b0001, 16'hFFFF, d3, 1'b1, 1'b0);
        beat(4'b0010, 16'hFFFF, d2, 1'b1, 1'b0);
        beat(4'b0100, 16'hFFFF, d1, 1'b1, 1'b0);
        beat(4'b1000, 16'hFFFF, d0, 1'b1, 1'b1);
        check("rst_pre_valid", {255'd0, dat_valid}, 256'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_valid", {255'd0, dat_valid}, 256'd0);
        check("rst_busy",  {255'd0, busy},      256'd0);
        check("rst_wdrdy", {255'd0, wd_ready},  256'd1);
        dat_ready = 1'b1;
        beat(4'b0001, 16'h000F, 128'h1122_3344, 1'b1, 1'b1);
        check("post_rst_valid",  {255'd0, dat_valid},  256'd1);
        check("post_rst_dataid", {254'd0, dat_dataid}, 256'd0);
        check("post_rst_be",     {224'd0, dat_be},     {224'd0, 32'h0000_000F});
        check("post_rst_last",   {255'd0, dat_last},   256'd1);
        check("post_rst_data",   {224'd0, dat_data[31:0]}, {224'd0, 32'h1122_3344});
        step();
        check("post_rst_end", {255'd0, busy}, 256'd0);

`ifdef RNI_WPACK_DATACHECK_EN
        // Byte 0 = 0x01 (already odd), every other byte 0x00.
        beat(4'b0001, 16'hFFFF, 128'h1, 1'b1, 1'b1);
        check("datacheck_lo", {240'd0, dat_datacheck[15:0]}, {240'd0, 16'hFFFE});
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
